// File: rtl/wgt_pingpong_buf.sv
// wgt_pingpong_buf
//
// Two-bank weight buffer sitting between img2col_weight and the cube weight
// port. One bank is filled from the img2col write port while the other bank
// is streamed out to the cube, so kernel rearrangement overlaps consumption.
//
// Ports:
//   clock, rst               - single rising-edge clock, async active-high reset
//   wgt_wr_en/addr/data      - row write from img2col_weight
//   wgt_wr_num_valid         - lane count stored alongside each row
//   wgt_fill_done            - pulse that closes the bank being filled
//   wgt_bank_free            - fill bank can take writes (EMPTY or FILLING)
//   cube_rd_avail            - at least one bank is FULL
//   cube_rd_start            - request to stream the oldest FULL bank
//   cube_wgt_valid/ready     - output handshake
//   cube_wgt_data/num_valid  - output row and its lane count
//   cube_wgt_last            - marks the final row of the bank
//   err_ovf                  - sticky drop/misuse flag, cleared only by rst
module wgt_pingpong_buf #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wgt_wr_en,
    input  logic [ADDR_W-1:0] wgt_wr_addr,
    input  logic [DATA_W-1:0] wgt_wr_data,
    input  logic [3:0]        wgt_wr_num_valid,
    input  logic              wgt_fill_done,
    output logic              wgt_bank_free,
    output logic              cube_rd_avail,
    input  logic              cube_rd_start,
    output logic              cube_wgt_valid,
    input  logic              cube_wgt_ready,
    output logic [DATA_W-1:0] cube_wgt_data,
    output logic [3:0]        cube_wgt_num_valid,
    output logic              cube_wgt_last,
    output logic              err_ovf
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_READING = 2'd3;

    localparam int LEN_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ROW_W = DATA_W + 4;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    logic [ROW_W-1:0] mem [2][DEPTH];
    logic [1:0]       bank_state [2];
    logic [LEN_W-1:0] len_q [2];
    logic             fb;
    logic             rb;
    logic [LEN_W-1:0] rd_row;

    logic fill_open;
    logic wr_accept;
    logic wr_drop;
    logic fill_close;
    logic fill_bad;
    logic rd_accept;
    logic rd_advance;
    logic rd_more;
    logic rd_load;
    logic rd_end;

    // The fill bank only ever sits in EMPTY/FILLING when it changes and the
    // read bank only in FULL/READING, so the two paths never touch the same
    // bank in one cycle even when fb == rb.
    always_comb begin
        fill_open  = (bank_state[fb] == ST_EMPTY) || (bank_state[fb] == ST_FILLING);
        wr_accept  = wgt_wr_en && fill_open && (len_q[fb] != LEN_MAX);
        wr_drop    = wgt_wr_en && !wr_accept;
        fill_close = wgt_fill_done && ((bank_state[fb] == ST_FILLING) || wr_accept);
        fill_bad   = wgt_fill_done && !fill_open;
        rd_accept  = cube_rd_start && (bank_state[rb] == ST_FULL);
        rd_advance = (bank_state[rb] == ST_READING) && (!cube_wgt_valid || cube_wgt_ready);
        rd_more    = rd_row < len_q[rb];
        rd_load    = rd_advance && rd_more;
        rd_end     = rd_advance && !rd_more;
    end

    assign wgt_bank_free = fill_open;
    assign cube_rd_avail = (bank_state[0] == ST_FULL) || (bank_state[1] == ST_FULL);

    // Bank bookkeeping. A write coinciding with fill_done is counted before
    // the bank is closed, which is why fill_close also looks at wr_accept.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bank_state[0] <= ST_EMPTY;
            bank_state[1] <= ST_EMPTY;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            fb            <= 1'b0;
            rb            <= 1'b0;
            err_ovf       <= 1'b0;
        end else begin
            if (wr_accept) begin
                len_q[fb]      <= len_q[fb] + LEN_W'(1);
                bank_state[fb] <= ST_FILLING;
            end
            if (fill_close) begin
                bank_state[fb] <= ST_FULL;
                fb             <= ~fb;
            end
            if (rd_accept) begin
                bank_state[rb] <= ST_READING;
            end
            if (rd_end) begin
                bank_state[rb] <= ST_EMPTY;
                len_q[rb]      <= '0;
                rb             <= ~rb;
            end
            if (wr_drop || fill_bad) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Row storage is deliberately not reset so a reset costs nothing in the
    // array; stale rows are never streamed because len is cleared.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[fb][wgt_wr_addr] <= {wgt_wr_num_valid, wgt_wr_data};
        end
    end

    // Output stage: rd_row is the next row to load. The start loads row 0
    // directly so it is visible the cycle after the request; the beat after
    // the last accepted row finds rd_row == len and retires the bank.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cube_wgt_valid     <= 1'b0;
            cube_wgt_last      <= 1'b0;
            cube_wgt_data      <= '0;
            cube_wgt_num_valid <= '0;
            rd_row             <= '0;
        end else if (rd_accept) begin
            {cube_wgt_num_valid, cube_wgt_data} <= mem[rb][0];
            cube_wgt_valid <= 1'b1;
            cube_wgt_last  <= (len_q[rb] == LEN_W'(1));
            rd_row         <= LEN_W'(1);
        end else if (rd_load) begin
            {cube_wgt_num_valid, cube_wgt_data} <= mem[rb][rd_row[ADDR_W-1:0]];
            cube_wgt_valid <= 1'b1;
            cube_wgt_last  <= ((rd_row + LEN_W'(1)) == len_q[rb]);
            rd_row         <= rd_row + LEN_W'(1);
        end else if (rd_end) begin
            cube_wgt_valid <= 1'b0;
            cube_wgt_last  <= 1'b0;
        end
    end

endmodule
